qeciphy_clk_mmcm_ctrl: RTL and testbench

//  Reset/health sequencer for the qeciphy_clk_mmcm clocking block, on the free-running clk.
//  - Drives the MMCM reset.
//  - Consumes the MMCM input_clk_stopped flag and a toggle heartbeat from the clk_out domain.
//  - Declares clk_ready once the generated clock is proven alive.
//  - Re-sequences automatically on a clock stop or a heartbeat loss.

---
 rtl/qeciphy_pkg.sv | 18 +
 rtl/qeciphy_bit_sync.sv | 24 ++
 rtl/qeciphy_clk_mmcm_ctrl.sv | 155 +++++++++++++++
 tb/tb_qeciphy_clk_mmcm_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/qeciphy_pkg.sv
// Shared types and constants for the qeciphy clocking and reset blocks.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } mmcm_ctrl_state_t;

  localparam int MMCM_RETRY_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qeciphy_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level into the clk domain.
module qeciphy_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/qeciphy_clk_mmcm_ctrl.sv
// Reset/health sequencer for the MMCM: holds it in reset, waits for a live
// heartbeat from the generated clock, then watches for stops or heartbeat loss.
module qeciphy_clk_mmcm_ctrl
  import qeciphy_pkg::*;
#(
  parameter int RESET_CYCLES    = 64,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int HB_EDGES        = 16,
  parameter int WATCHDOG_CYCLES = 256,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clk_stopped,
  input  logic                    hb_toggle,
  output logic                    mmcm_reset,
  output logic                    clk_ready,
  output logic                    fault,
  output logic [MMCM_RETRY_W-1:0] retry_count,
  output logic [1:0]              state_dbg
);

  localparam int TMAX    = max3(LOCK_TIMEOUT, RESET_CYCLES, WATCHDOG_CYCLES);
  localparam int TIMER_W = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam int ECNT_W  = $clog2(HB_EDGES + 1);

  localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WD_LAST   = TIMER_W'(WATCHDOG_CYCLES - 1);
  localparam logic [ECNT_W-1:0]  HB_MAX    = ECNT_W'(HB_EDGES);

  logic stopped_s, hb_s;
  logic hb_prev_q, hb_prev_d;
  logic hb_edge;

  qeciphy_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_stopped (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_stopped),
    .q     (stopped_s)
  );

  qeciphy_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_hb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (hb_toggle),
    .q     (hb_s)
  );

  assign hb_prev_d = hb_s;
  assign hb_edge   = hb_s ^ hb_prev_q;

  mmcm_ctrl_state_t          state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [ECNT_W-1:0]         edge_cnt_q, edge_cnt_d;
  logic [MMCM_RETRY_W-1:0]   retry_q, retry_d;
  logic                      fault_q, fault_d;
  logic                      mmcm_reset_q, mmcm_reset_d;
  logic                      clk_ready_q, clk_ready_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    retry_d    = retry_q;
    fault_d    = fault_q;

    if (!enable) begin
      // Disable is an orderly shutdown: no fault, no retry accounting.
      state_d    = S_RESET;
      timer_d    = '0;
      edge_cnt_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d    = S_WAIT;
            timer_d    = '0;
            edge_cnt_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        S_WAIT: begin
          timer_d = timer_q + 1'b1;
          if (stopped_s)
            edge_cnt_d = '0;
          else if (hb_edge && (edge_cnt_q != HB_MAX))
            edge_cnt_d = edge_cnt_q + 1'b1;

          // A lock proven on the last allowed cycle still counts.
          if (edge_cnt_d == HB_MAX) begin
            state_d = S_READY;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            state_d = S_RESET;
            timer_d = '0;
            if (retry_q != '1) retry_d = retry_q + 1'b1;
          end
        end

        S_READY: begin
          timer_d = hb_edge ? '0 : timer_q + 1'b1;
          if (stopped_s || ((timer_q == WD_LAST) && !hb_edge)) begin
            state_d    = S_RESET;
            timer_d    = '0;
            edge_cnt_d = '0;
            fault_d    = 1'b1;
          end
        end

        default: begin
          state_d    = S_RESET;
          timer_d    = '0;
          edge_cnt_d = '0;
        end
      endcase
    end

    // Outputs follow the next state so clk_ready and mmcm_reset swap on one edge.
    mmcm_reset_d = (state_d == S_RESET);
    clk_ready_d  = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      retry_q      <= '0;
      fault_q      <= 1'b0;
      mmcm_reset_q <= 1'b1;
      clk_ready_q  <= 1'b0;
      hb_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      retry_q      <= retry_d;
      fault_q      <= fault_d;
      mmcm_reset_q <= mmcm_reset_d;
      clk_ready_q  <= clk_ready_d;
      hb_prev_q    <= hb_prev_d;
    end
  end

  assign mmcm_reset  = mmcm_reset_q;
  assign clk_ready   = clk_ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_qeciphy_clk_mmcm_ctrl.sv
// Directed bench for the MMCM reset/health sequencer; LOCK_TIMEOUT is shortened
// so the retry-saturation scenario stays short.
module tb_qeciphy_clk_mmcm_ctrl;
  import qeciphy_pkg::*;

  localparam int RC = 64;
  localparam int LT = 128;
  localparam int HE = 16;
  localparam int WD = 256;

  logic       clk = 1'b0;
  logic       rst_n, enable, clk_stopped, hb_toggle;
  logic       mmcm_reset, clk_ready, fault;
  logic [7:0] retry_count;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int hb_div = 0;
  logic hb_en = 1'b0;

  qeciphy_clk_mmcm_ctrl #(
    .RESET_CYCLES    (RC),
    .LOCK_TIMEOUT    (LT),
    .HB_EDGES        (HE),
    .WATCHDOG_CYCLES (WD),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clk_stopped (clk_stopped),
    .hb_toggle   (hb_toggle),
    .mmcm_reset  (mmcm_reset),
    .clk_ready   (clk_ready),
    .fault       (fault),
    .retry_count (retry_count),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      hb_div++;
      if (hb_en && (hb_div % 4 == 0)) hb_toggle = ~hb_toggle;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (!clk_ready && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(clk_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b1; clk_stopped = 1'b0; hb_toggle = 1'b0;

    // Reset values
    tick(3);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_mmcm_reset", 32'(mmcm_reset), 32'd1);
    chk("rst_clk_ready", 32'(clk_ready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);

    // 1: 64-cycle reset, then lock on the 16th heartbeat edge + sync latency
    rst_n = 1'b1;
    tick(RC - 1);
    chk("t1_mmcm_held", 32'(mmcm_reset), 32'd1);
    tick(1);
    chk("t1_mmcm_released", 32'(mmcm_reset), 32'd0);
    chk("t1_state_wait", 32'(state_dbg), 32'd1);
    hb_en = 1'b1; hb_div = 0;
    tick(66);
    chk("t1_not_ready_early", 32'(clk_ready), 32'd0);
    tick(1);
    chk("t1_ready", 32'(clk_ready), 32'd1);
    chk("t1_state_ready", 32'(state_dbg), 32'd2);
    chk("t1_retry", 32'(retry_count), 32'd0);

    // 3: 3-cycle clk_stopped pulse in READY
    clk_stopped = 1'b1;
    tick(2);
    chk("t3_ready_before_sync", 32'(clk_ready), 32'd1);
    tick(1);
    clk_stopped = 1'b0;
    chk("t3_ready_drop", 32'(clk_ready), 32'd0);
    chk("t3_mmcm_reset", 32'(mmcm_reset), 32'd1);
    chk("t3_fault", 32'(fault), 32'd1);
    wait_ready("t3_relock", 300);
    chk("t3_fault_sticky", 32'(fault), 32'd1);
    chk("t3_retry", 32'(retry_count), 32'd0);

    // 6: one-cycle rst_n mid-READY, then an illegal state encoding
    tick(7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t6_state", 32'(state_dbg), 32'd0);
    chk("t6_mmcm_reset", 32'(mmcm_reset), 32'd1);
    chk("t6_clk_ready", 32'(clk_ready), 32'd0);
    chk("t6_fault", 32'(fault), 32'd0);
    chk("t6_retry", 32'(retry_count), 32'd0);
    force dut.state_q = mmcm_ctrl_state_t'(2'd3);
    #1;
    chk("t6_forced_dbg", 32'(state_dbg), 32'd3);
    tick(1);
    release dut.state_q;
    tick(1);
    chk("t6_illegal_recover", 32'(state_dbg), 32'd0);
    chk("t6_illegal_no_fault", 32'(fault), 32'd0);
    chk("t6_illegal_mmcm", 32'(mmcm_reset), 32'd1);

    // 5: drop enable in S_WAIT, then restore
    n = 0;
    while (state_dbg != 2'd1 && n < 200) begin tick(1); n++; end
    chk("t5_reach_wait", 32'(state_dbg), 32'd1);
    tick(5);
    enable = 1'b0;
    tick(1);
    chk("t5_state_reset", 32'(state_dbg), 32'd0);
    chk("t5_fault", 32'(fault), 32'd0);
    chk("t5_retry", 32'(retry_count), 32'd0);
    chk("t5_mmcm_reset", 32'(mmcm_reset), 32'd1);
    tick(10);
    chk("t5_hold_disabled", 32'(state_dbg), 32'd0);
    enable = 1'b1;
    tick(RC - 1);
    chk("t5_full_reset", 32'(state_dbg), 32'd0);
    tick(1);
    chk("t5_wait_after", 32'(state_dbg), 32'd1);
    wait_ready("t5_relock", 200);

    // 4: heartbeat stops in READY; watchdog trips 256 cycles after the last edge
    n = 0;
    while (hb_div % 4 != 0 && n < 8) begin tick(1); n++; end
    hb_en = 1'b0;
    chk("t4_ready_at_stop", 32'(clk_ready), 32'd1);
    tick(2 + WD);
    chk("t4_ready_before_trip", 32'(clk_ready), 32'd1);
    tick(1);
    chk("t4_trip_ready", 32'(clk_ready), 32'd0);
    chk("t4_trip_state", 32'(state_dbg), 32'd0);
    chk("t4_trip_fault", 32'(fault), 32'd1);

    // 2: no heartbeat; each attempt is 64 reset + 128 wait cycles
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(RC + LT - 1);
    chk("t2_retry_before", 32'(retry_count), 32'd0);
    chk("t2_still_wait", 32'(state_dbg), 32'd1);
    tick(1);
    chk("t2_retry_1", 32'(retry_count), 32'd1);
    chk("t2_back_to_reset", 32'(state_dbg), 32'd0);
    chk("t2_mmcm_reset", 32'(mmcm_reset), 32'd1);
    tick((RC + LT) * 253);
    chk("t2_retry_254", 32'(retry_count), 32'd254);
    tick(RC + LT);
    chk("t2_retry_255", 32'(retry_count), 32'd255);
    tick((RC + LT) * 2);
    chk("t2_retry_sat", 32'(retry_count), 32'd255);
    chk("t2_no_fault", 32'(fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
